// File: rtl/sram_extension_pkg.sv
// Shared geometry for the depth-extended scratch SRAM: word width, address split and bank count.
package sram_extension_pkg;

   localparam int unsigned DWIDTH     = 64;
   localparam int unsigned AWIDTH     = 6;
   localparam int unsigned NBANK      = 4;
   localparam int unsigned SEL_W      = $clog2(NBANK);
   localparam int unsigned BANK_AW    = AWIDTH - SEL_W;
   localparam int unsigned BANK_DEPTH = (2 ** AWIDTH) / NBANK;

   typedef logic [DWIDTH-1:0]  word_t;
   typedef logic [BANK_AW-1:0] bank_addr_t;
   typedef logic [SEL_W-1:0]   bank_sel_t;

   function automatic bank_sel_t bank_of(input logic [AWIDTH-1:0] addr);
      return addr[AWIDTH-1:BANK_AW];
   endfunction

endpackage

// File: rtl/sram_bank.sv
// One single-port bank: synchronous write, registered read, write wins when both are requested.
module sram_bank
   import sram_extension_pkg::*;
(
   input  logic               i_clk,
   input  logic               i_cen,
   input  logic               i_wen,
   input  logic [BANK_AW-1:0] i_addr,
   input  logic [DWIDTH-1:0]  i_data,
   output logic [DWIDTH-1:0]  o_data
);

   word_t mem [BANK_DEPTH];

   // Array and read register are deliberately unreset; contents survive a reset pulse.
   always_ff @(posedge i_clk) begin
      if (i_cen && i_wen) begin
         mem[i_addr] <= i_data;
      end else if (i_cen) begin
         o_data <= mem[i_addr];
      end
   end

endmodule

// File: rtl/sram_extension.sv
// 64x64 single-port SRAM built from four 16x64 banks selected by a one-hot chip-enable vector.
module sram_extension
   import sram_extension_pkg::*;
(
   input  logic              i_clk,
   input  logic              i_rstn,
   input  logic [DWIDTH-1:0] i_data,
   input  logic [AWIDTH-1:0] i_addr,
   input  logic              i_wen,
   input  logic              i_oen,
   output logic [DWIDTH-1:0] o_data
);

   logic [NBANK-1:0] cen;
   logic [NBANK-1:0] bank_cen;
   word_t            bank_rdata [NBANK];
   word_t            rd_word;
   word_t            data_q;
   bank_sel_t        sel_q;
   logic             rd_q;
   logic             rd_d;

   always_comb begin
      cen = '0;
      if (i_wen || i_oen) begin
         cen[bank_of(i_addr)] = 1'b1;
      end
   end

   // Banks have no reset of their own, so accesses are blocked here while reset is held.
   assign bank_cen = cen & {NBANK{i_rstn}};
   assign rd_d     = i_oen & ~i_wen;

   for (genvar k = 0; k < NBANK; k++) begin : g_bank
      sram_bank u_bank (
         .i_clk  (i_clk),
         .i_cen  (bank_cen[k]),
         .i_wen  (i_wen),
         .i_addr (i_addr[BANK_AW-1:0]),
         .i_data (i_data),
         .o_data (bank_rdata[k])
      );
   end

   always_comb begin
      rd_word = bank_rdata[sel_q];
   end

   // rd_q marks the cycle right after a read edge, when the selected bank register holds
   // fresh data; data_q captures that word so it persists through standby and writes.
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         rd_q   <= 1'b0;
         sel_q  <= '0;
         data_q <= '0;
      end else begin
         rd_q <= rd_d;
         if (rd_d) begin
            sel_q <= bank_of(i_addr);
         end
         if (rd_q) begin
            data_q <= rd_word;
         end
      end
   end

   assign o_data = rd_q ? rd_word : data_q;

endmodule

// File: tb/tb_sram_extension.sv
// Directed bench for sram_extension: fill/read-back, bank decode, isolation, hold, reset, RAW.
module tb_sram_extension;

   logic        clk;
   logic        rstn;
   logic [63:0] data;
   logic [5:0]  addr;
   logic        wen;
   logic        oen;
   logic [63:0] q;

   int errors = 0;
   int checks = 0;

   sram_extension dut (
      .i_clk  (clk),
      .i_rstn (rstn),
      .i_data (data),
      .i_addr (addr),
      .i_wen  (wen),
      .i_oen  (oen),
      .o_data (q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [5:0] a, input logic [63:0] d);
      addr = a; data = d; wen = 1'b1; oen = 1'b0;
      tick();
   endtask

   task automatic rd(input logic [5:0] a);
      addr = a; wen = 1'b0; oen = 1'b1;
      tick();
   endtask

   task automatic idle();
      wen = 1'b0; oen = 1'b0;
      tick();
   endtask

   initial begin
      rstn = 1'b0; data = '0; addr = '0; wen = 1'b0; oen = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_odata", q, 64'h0);
      rstn = 1'b1;
      tick();
      check("post_release_odata", q, 64'h0);

      // Fill then read back every address
      for (int i = 0; i < 64; i++) wr(6'(i), 64'(i));
      for (int i = 0; i < 64; i++) begin
         rd(6'(i));
         check($sformatf("readback_%0d", i), q, 64'(i));
      end

      // Bank decode, observed combinationally without clocking
      wen = 1'b0; oen = 1'b1;
      addr = 6'h05; #1; check("cen_0x05", 64'(dut.cen), 64'b0001);
      addr = 6'h15; #1; check("cen_0x15", 64'(dut.cen), 64'b0010);
      addr = 6'h25; #1; check("cen_0x25", 64'(dut.cen), 64'b0100);
      addr = 6'h3F; #1; check("cen_0x3f", 64'(dut.cen), 64'b1000);
      oen = 1'b0;   #1; check("cen_standby", 64'(dut.cen), 64'b0000);
      wen = 1'b1;   #1; check("cen_write_0x3f", 64'(dut.cen), 64'b1000);
      wen = 1'b0;
      tick();

      // Bank isolation
      wr(6'h03, 64'hAAAA_AAAA_AAAA_AAAA);
      wr(6'h13, 64'h5555_5555_5555_5555);
      rd(6'h03); check("iso_0x03", q, 64'hAAAA_AAAA_AAAA_AAAA);
      rd(6'h13); check("iso_0x13", q, 64'h5555_5555_5555_5555);
      rd(6'h23); check("iso_0x23", q, 64'h23);

      // Hold in standby, then write-priority on wen=oen=1
      rd(6'h07); check("read_7", q, 64'h7);
      for (int i = 0; i < 5; i++) begin
         idle();
         check($sformatf("hold_%0d", i), q, 64'h7);
      end
      addr = 6'h07; data = 64'hFF; wen = 1'b1; oen = 1'b1;
      tick();
      check("both_en_hold", q, 64'h7);
      idle();
      check("both_en_hold2", q, 64'h7);
      rd(6'h07); check("read_7_after_write", q, 64'hFF);

      // Reset pulse between edges during a read sequence
      rd(6'h08); check("read_8", q, 64'h8);
      addr = 6'h09; oen = 1'b1;
      #2 rstn = 1'b0;
      #1 check("async_reset_odata", q, 64'h0);
      oen = 1'b0;
      #1 rstn = 1'b1;
      #1 check("reset_release_odata", q, 64'h0);
      tick();
      check("post_reset_standby", q, 64'h0);
      rd(6'h0A); check("read_10_after_reset", q, 64'hA);

      // Write then read on the very next cycle
      wr(6'h2C, 64'h1234);
      rd(6'h2C); check("raw_0x2c", q, 64'h1234);
      idle();
      check("raw_hold", q, 64'h1234);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
